hamming_rx_ctrl: RTL and testbench

Frame controller for the serial Hamming(7,4) receive path. It detects a start bit on the serial line and shifts in one 7-bit codeword, then computes syndrome, error pattern and corrected word. Each decoded word is handed downstream through a one-deep valid/ready output register, and the block keeps saturating word, correction and overrun status. It sits between the serial line and the consumer, and owns all sequencing of the syndrome decoder.

---
 rtl/hamming_pkg.sv | 15 +
 rtl/hamming74_syndrome.sv | 31 +++
 rtl/hamming_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_hamming_rx_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and syndrome helper for the Hamming(7,4) receive path.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  typedef enum logic {IDLE, RECV} state_e;

  // Syndrome value s names codeword position s, which lives at r[7-s].
  function automatic logic [SYN_W-1:0] err_bit_idx(input logic [SYN_W-1:0] syn);
    return SYN_W'(CODE_W) - syn;
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) decoder: syndrome, single-bit error pattern, corrected word, data.
module hamming74_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] r_i,
  output logic [SYN_W-1:0]  s_o,
  output logic [CODE_W-1:0] e_o,
  output logic [CODE_W-1:0] t_o,
  output logic [DATA_W-1:0] data_o
);

  logic [SYN_W-1:0] syn;

  always_comb begin
    syn[0] = r_i[6] ^ r_i[4] ^ r_i[2] ^ r_i[0];
    syn[1] = r_i[5] ^ r_i[4] ^ r_i[1] ^ r_i[0];
    syn[2] = r_i[3] ^ r_i[2] ^ r_i[1] ^ r_i[0];
  end

  always_comb begin
    e_o = '0;
    if (syn != '0) begin
      e_o = CODE_W'(1) << err_bit_idx(syn);
    end
  end

  assign s_o    = syn;
  assign t_o    = r_i ^ e_o;
  assign data_o = {t_o[4], t_o[2], t_o[1], t_o[0]};

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Serial Hamming(7,4) frame receiver: start-bit FSM, shift register, decoder, one-deep
// valid/ready output register and saturating status counters.
module hamming_rx_ctrl
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              out_ready,
  input  logic              clr,
  output logic              out_valid,
  output logic [CODE_W-1:0] r,
  output logic [SYN_W-1:0]  s,
  output logic [CODE_W-1:0] e,
  output logic [CODE_W-1:0] t,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic              overrun
);

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [CODE_W-1:0]  shift_q, shift_d;
  logic               done;

  logic [SYN_W-1:0]   dec_s;
  logic [CODE_W-1:0]  dec_e, dec_t;
  logic [DATA_W-1:0]  dec_data;

  logic               out_valid_q, out_valid_d;
  logic [CODE_W-1:0]  r_q, e_q, t_q;
  logic [SYN_W-1:0]   s_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d, corr_cnt_q, corr_cnt_d;
  logic               overrun_q, overrun_d;
  logic               load, drop;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        shift_d   = {shift_q[CODE_W-2:0], in};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd6) begin
          done      = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the word including the bit being shifted in, so the result is ready on done.
  hamming74_syndrome u_syndrome (
    .r_i    (shift_d),
    .s_o    (dec_s),
    .e_o    (dec_e),
    .t_o    (dec_t),
    .data_o (dec_data)
  );

  always_comb begin
    load        = done && (!out_valid_q || out_ready);
    drop        = done && out_valid_q && !out_ready;
    out_valid_d = load || (out_valid_q && !out_ready);

    word_cnt_d = word_cnt_q;
    corr_cnt_d = corr_cnt_q;
    overrun_d  = overrun_q || drop;
    if (load && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
    if (load && (dec_s != '0) && (corr_cnt_q != '1)) begin
      corr_cnt_d = corr_cnt_q + CNT_W'(1);
    end
    if (clr) begin
      word_cnt_d = '0;
      corr_cnt_d = '0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      s_q         <= '0;
      e_q         <= '0;
      t_q         <= '0;
      data_q      <= '0;
      word_cnt_q  <= '0;
      corr_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
      corr_cnt_q  <= corr_cnt_d;
      overrun_q   <= overrun_d;
      if (load) begin
        r_q    <= shift_d;
        s_q    <= dec_s;
        e_q    <= dec_e;
        t_q    <= dec_t;
        data_q <= dec_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign s         = s_q;
  assign e         = e_q;
  assign t         = t_q;
  assign data      = data_q;
  assign busy      = (state_q == RECV);
  assign word_cnt  = word_cnt_q;
  assign corr_cnt  = corr_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Directed bench for hamming_rx_ctrl: decode table plus handshake, overrun, clr, reset and
// saturation sequences; a CNT_W=2 instance shares the stimulus for the saturation checks.
module tb_hamming_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n, ser_in, out_ready, clr;

  logic       valid16, busy16, ovr16;
  logic [6:0] r16, e16, t16;
  logic [2:0] s16;
  logic [3:0] data16;
  logic [15:0] wcnt16, ccnt16;

  logic       valid2, busy2, ovr2;
  logic [6:0] r2, e2, t2;
  logic [2:0] s2;
  logic [3:0] data2;
  logic [1:0] wcnt2, ccnt2;

  int n_tests = 0;
  int n_fail  = 0;
  logic first_busy, last_busy, last_valid;

  always #5 clk = ~clk;

  hamming_rx_ctrl #(.CNT_W(16)) dut16 (
    .clk(clk), .reset(rst_n), .in(ser_in), .out_ready(out_ready), .clr(clr),
    .out_valid(valid16), .r(r16), .s(s16), .e(e16), .t(t16), .data(data16),
    .busy(busy16), .word_cnt(wcnt16), .corr_cnt(ccnt16), .overrun(ovr16)
  );

  hamming_rx_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(rst_n), .in(ser_in), .out_ready(out_ready), .clr(clr),
    .out_valid(valid2), .r(r2), .s(s2), .e(e2), .t(t2), .data(data2),
    .busy(busy2), .word_cnt(wcnt2), .corr_cnt(ccnt2), .overrun(ovr2)
  );

  typedef struct {
    logic [6:0] code;
    logic [2:0] s;
    logic [6:0] e;
    logic [6:0] t;
    logic [3:0] data;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start bit then 7 code bits MSB first; returns in the cycle after done (cycle n+8).
  task automatic send_frame(input logic [6:0] code, input logic rdy_last, input logic clr_last);
    ser_in = 1'b1;
    @(negedge clk);
    first_busy = busy16;
    for (int i = 6; i >= 0; i--) begin
      ser_in = code[i];
      if (i == 0) begin
        last_busy  = busy16;
        last_valid = valid16;
        out_ready  = rdy_last;
        clr        = clr_last;
      end
      @(negedge clk);
    end
    ser_in = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid16), 32'd0);
    chk({tag, "_busy"},  32'(busy16),  32'd0);
    chk({tag, "_r"},     32'(r16),     32'd0);
    chk({tag, "_s"},     32'(s16),     32'd0);
    chk({tag, "_e"},     32'(e16),     32'd0);
    chk({tag, "_t"},     32'(t16),     32'd0);
    chk({tag, "_data"},  32'(data16),  32'd0);
    chk({tag, "_wcnt"},  32'(wcnt16),  32'd0);
    chk({tag, "_ccnt"},  32'(ccnt16),  32'd0);
    chk({tag, "_ovr"},   32'(ovr16),   32'd0);
    chk({tag, "_ccnt2"}, 32'(ccnt2),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int model_w, model_c;
    vecs[0] = '{7'b0110011, 3'b000, 7'b0000000, 7'b0110011, 4'b1011};
    vecs[1] = '{7'b0110111, 3'b101, 7'b0000100, 7'b0110011, 4'b1011};
    vecs[2] = '{7'b0000000, 3'b000, 7'b0000000, 7'b0000000, 4'b0000};
    vecs[3] = '{7'b1111111, 3'b000, 7'b0000000, 7'b1111111, 4'b1111};
    vecs[4] = '{7'b1110011, 3'b001, 7'b1000000, 7'b0110011, 4'b1011};
    vecs[5] = '{7'b0110010, 3'b111, 7'b0000001, 7'b0110011, 4'b1011};
    vecs[6] = '{7'b0010000, 3'b011, 7'b0010000, 7'b0000000, 4'b0000};
    vecs[7] = '{7'b1110111, 3'b100, 7'b0001000, 7'b1111111, 4'b1111};
    vecs[8] = '{7'b0000010, 3'b110, 7'b0000010, 7'b0000000, 4'b0000};
    vecs[9] = '{7'b0100000, 3'b010, 7'b0100000, 7'b0000000, 4'b0000};

    rst_n = 1'b0; ser_in = 1'b0; out_ready = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Decode table with the consumer always ready.
    model_w = 0;
    model_c = 0;
    foreach (vecs[i]) begin
      send_frame(vecs[i].code, 1'b1, 1'b0);
      model_w++;
      if (vecs[i].s != 3'b000) model_c++;
      chk($sformatf("v%0d_busy_first", i), 32'(first_busy), 32'd1);
      chk($sformatf("v%0d_busy_last", i),  32'(last_busy),  32'd1);
      chk($sformatf("v%0d_valid_early", i), 32'(last_valid), 32'd0);
      chk($sformatf("v%0d_valid", i), 32'(valid16), 32'd1);
      chk($sformatf("v%0d_busy_after", i), 32'(busy16), 32'd0);
      chk($sformatf("v%0d_r", i), 32'(r16), 32'(vecs[i].code));
      chk($sformatf("v%0d_s", i), 32'(s16), 32'(vecs[i].s));
      chk($sformatf("v%0d_e", i), 32'(e16), 32'(vecs[i].e));
      chk($sformatf("v%0d_t", i), 32'(t16), 32'(vecs[i].t));
      chk($sformatf("v%0d_data", i), 32'(data16), 32'(vecs[i].data));
      chk($sformatf("v%0d_wcnt", i), 32'(wcnt16), 32'(model_w));
      chk($sformatf("v%0d_ccnt", i), 32'(ccnt16), 32'(model_c));
      chk($sformatf("v%0d_wcnt2", i), 32'(wcnt2), 32'((model_w > 3) ? 3 : model_w));
      chk($sformatf("v%0d_ccnt2", i), 32'(ccnt2), 32'((model_c > 3) ? 3 : model_c));
    end

    // Plain clr pulse.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_wcnt", 32'(wcnt16), 32'd0);
    chk("clr_ccnt", 32'(ccnt16), 32'd0);
    chk("clr_ccnt2", 32'(ccnt2), 32'd0);
    chk("clr_ovr", 32'(ovr16), 32'd0);

    // Consumer stalled over two back-to-back frames: second frame is dropped.
    out_ready = 1'b0;
    send_frame(7'b0000000, 1'b0, 1'b0);
    chk("ovr_first_valid", 32'(valid16), 32'd1);
    chk("ovr_first_wcnt", 32'(wcnt16), 32'd1);
    send_frame(7'b1111111, 1'b0, 1'b0);
    chk("ovr_hold_valid", 32'(valid16), 32'd1);
    chk("ovr_hold_r", 32'(r16), 32'h00);
    chk("ovr_hold_data", 32'(data16), 32'h0);
    chk("ovr_flag", 32'(ovr16), 32'd1);
    chk("ovr_flag2", 32'(ovr2), 32'd1);
    chk("ovr_wcnt", 32'(wcnt16), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", 32'(valid16), 32'd0);
    chk("ovr_sticky", 32'(ovr16), 32'd1);

    // Ready arrives in the same cycle as a completing frame: reload, no overrun.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b0;
    send_frame(7'b0110011, 1'b0, 1'b0);
    chk("coin_a_r", 32'(r16), 32'h33);
    send_frame(7'b0110111, 1'b1, 1'b0);
    chk("coin_valid", 32'(valid16), 32'd1);
    chk("coin_r", 32'(r16), 32'h37);
    chk("coin_s", 32'(s16), 32'h5);
    chk("coin_ovr", 32'(ovr16), 32'd0);
    chk("coin_wcnt", 32'(wcnt16), 32'd2);
    chk("coin_ccnt", 32'(ccnt16), 32'd1);

    // clr coincident with done: word still loads, counters read 0.
    send_frame(7'b0010000, 1'b1, 1'b1);
    chk("clrdone_valid", 32'(valid16), 32'd1);
    chk("clrdone_r", 32'(r16), 32'h10);
    chk("clrdone_wcnt", 32'(wcnt16), 32'd0);
    chk("clrdone_ccnt", 32'(ccnt16), 32'd0);
    chk("clrdone_ccnt2", 32'(ccnt2), 32'd0);
    chk("clrdone_ovr", 32'(ovr16), 32'd0);

    // Reset asserted at the 4th code bit of a frame.
    ser_in = 1'b1;
    @(negedge clk);
    ser_in = 1'b0; @(negedge clk);
    ser_in = 1'b1; @(negedge clk);
    ser_in = 1'b1; @(negedge clk);
    ser_in = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n  = 1'b1;
    ser_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle_busy", 32'(busy16), 32'd0);
    chk("midrst_idle_valid", 32'(valid16), 32'd0);
    send_frame(7'b1110011, 1'b1, 1'b0);
    chk("post_valid", 32'(valid16), 32'd1);
    chk("post_r", 32'(r16), 32'h73);
    chk("post_s", 32'(s16), 32'h1);
    chk("post_e", 32'(e16), 32'h40);
    chk("post_t", 32'(t16), 32'h33);
    chk("post_data", 32'(data16), 32'hb);
    chk("post_wcnt", 32'(wcnt16), 32'd1);
    chk("post_ccnt", 32'(ccnt16), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
